noc_c2m_arbiter: RTL and testbench

- Shares the single core-to-memory (C2M) downstream FIFO among RADIX core-side C2M FIFOs.
- Each cycle it picks one non-empty requester round-robin, with an optional burst hold.
- It dequeues that requester's flit into a one-entry output register, then enqueues the flit downstream when there is space.
- It sits inside NOC, between the per-core C2M FIFOs and the memory-side C2M FIFO.

---
 rtl/noc_pkg.sv | 10 +
 rtl/noc_c2m_arbiter_if.sv | 13 +
 rtl/noc_rr_pick.sv | 25 ++
 rtl/noc_c2m_arbiter.sv | 55 +++++
 tb/tb_noc_c2m_arbiter.sv | 101 ++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared NOC widths and flit/port-id types
package noc_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int FLIT_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int RADIX = 2;
  localparam int ID_W = $clog2(RADIX);
  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [ID_W-1:0] port_id_t;
endpackage

// File: rtl/noc_c2m_arbiter_if.sv
// noc_c2m_arbiter_if: core-side FIFO heads in, downstream C2M FIFO enqueue out
interface noc_c2m_arbiter_if import noc_pkg::*; #(parameter int N = 2);
  localparam int IW = $clog2(N);
  logic [N-1:0] req_empty;
  flit_t req_flit [N];
  logic [N-1:0] req_deq;
  logic out_enq;
  flit_t out_flit;
  logic out_full;
  logic [IW-1:0] out_src;
  modport master (input req_empty, req_flit, out_full, output req_deq, out_enq, out_flit, out_src);
  modport slave (output req_empty, req_flit, out_full, input req_deq, out_enq, out_flit, out_src);
endinterface

// File: rtl/noc_rr_pick.sv
// noc_rr_pick: combinational round-robin pick of the first request at or after ptr
module noc_rr_pick #(
  parameter int RADIX = 2,
  parameter int ID_W = $clog2(RADIX)
) (
  input  logic [RADIX-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [RADIX-1:0] gnt_onehot_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             any_o
);
  logic [2*RADIX-1:0] dbl;
  logic [RADIX-1:0] rot;
  int off, s;
  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[RADIX-1:0];
    off = 0;
    for (int i = RADIX - 1; i >= 0; i--) off = rot[i] ? i : off;
    s = int'(ptr_i) + off;
    gnt_id_o = ID_W'(s >= RADIX ? s - RADIX : s);
    any_o = |req_i;
    gnt_onehot_o = any_o ? RADIX'(1) << gnt_id_o : '0;
  end
endmodule

// File: rtl/noc_c2m_arbiter.sv
// noc_c2m_arbiter: round-robin (optional burst hold) C2M arbiter with one-entry output register
module noc_c2m_arbiter import noc_pkg::*; #(
  parameter int RADIX = 2,
  parameter int BURST_LEN = 1
) (
  input logic clk,
  input logic rst,
  noc_c2m_arbiter_if.master bus
);
  localparam int IW = $clog2(RADIX);
  localparam int BW = $clog2(BURST_LEN + 1);
  logic out_valid_q, out_valid_d;
  flit_t out_flit_q, out_flit_d;
  logic [IW-1:0] out_src_q, out_src_d, ptr_q, ptr_d, last_q, last_d, pick_id, g;
  logic [BW-1:0] burst_q, burst_d;
  logic [RADIX-1:0] req, pick_oh;
  logic any, ld, hold, grant;
  assign req = ~bus.req_empty;
  noc_rr_pick #(.RADIX(RADIX), .ID_W(IW)) u_pick (
    .req_i(req), .ptr_i(ptr_q), .gnt_onehot_o(pick_oh), .gnt_id_o(pick_id), .any_o(any)
  );
  always_comb begin
    ld = ~out_valid_q | ~bus.out_full;
    hold = (BURST_LEN > 1) && req[last_q] && (burst_q < BW'(BURST_LEN - 1));
    g = hold ? last_q : pick_id;
    grant = ld & any;
    bus.req_deq = (grant & ~rst) ? RADIX'(1) << g : '0;
    bus.out_enq = out_valid_q & ~bus.out_full & ~rst;
    bus.out_flit = out_flit_q;
    bus.out_src = out_src_q;
    out_valid_d = grant ? 1'b1 : (ld ? 1'b0 : out_valid_q);
    out_flit_d = grant ? bus.req_flit[g] : out_flit_q;
    out_src_d = grant ? g : out_src_q;
    last_d = grant ? g : last_q;
    burst_d = grant ? (hold ? BW'(burst_q + 1'b1) : '0) : burst_q;
    ptr_d = (grant & ~hold) ? ((g == IW'(RADIX - 1)) ? '0 : IW'(g + 1'b1)) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_flit_q <= '0;
      out_src_q <= '0;
      ptr_q <= '0;
      last_q <= '0;
      burst_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q <= out_flit_d;
      out_src_q <= out_src_d;
      ptr_q <= ptr_d;
      last_q <= last_d;
      burst_q <= burst_d;
    end
  end
endmodule

// File: tb/tb_noc_c2m_arbiter.sv
// tb_noc_c2m_arbiter: directed checks of round-robin, backpressure, burst hold and reset
module tb_noc_c2m_arbiter;
  import noc_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  localparam flit_t F0 = 64'h0FFF_FFFF_FFFF_FFFF;
  localparam flit_t F1 = 64'h1000_0000_0000_0000;
  always #5 clk = ~clk;
  noc_c2m_arbiter_if #(.N(2)) a ();
  noc_c2m_arbiter_if #(.N(2)) b ();
  noc_c2m_arbiter #(.RADIX(2), .BURST_LEN(1)) dut_a (.clk(clk), .rst(rst), .bus(a));
  noc_c2m_arbiter #(.RADIX(2), .BURST_LEN(3)) dut_b (.clk(clk), .rst(rst), .bus(b));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  logic [1:0] seq [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
  logic src_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  initial begin
    rst = 1'b1;
    a.req_empty = 2'b00; a.out_full = 1'b0; a.req_flit[0] = F0; a.req_flit[1] = F1;
    b.req_empty = 2'b11; b.out_full = 1'b0; b.req_flit[0] = F0; b.req_flit[1] = F1;
    repeat (2) begin
      cyc(); #1;
      chk("rst_deq", 64'(a.req_deq), 64'b00);
      chk("rst_enq", 64'(a.out_enq), 64'b0);
      chk("rst_flit", a.out_flit, 64'h0);
    end
    cyc(); rst = 1'b0; #1;
    chk("first_deq", 64'(a.req_deq), 64'b01);
    chk("first_enq", 64'(a.out_enq), 64'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(); #1;
      chk("rr_deq", 64'(a.req_deq), (i % 2) ? 64'b10 : 64'b01);
      chk("rr_enq", 64'(a.out_enq), 64'b1);
      chk("rr_flit", a.out_flit, (i % 2) ? F0 : F1);
      chk("rr_src", 64'(a.out_src), (i % 2) ? 64'd0 : 64'd1);
    end
    for (int j = 0; j < 3; j++) begin
      cyc(); a.out_full = 1'b1; #1;
      chk("bp_deq", 64'(a.req_deq), 64'b00);
      chk("bp_enq", 64'(a.out_enq), 64'b0);
      chk("bp_flit", a.out_flit, F1);
    end
    cyc(); a.out_full = 1'b0; #1;
    chk("bp_rel_enq", 64'(a.out_enq), 64'b1);
    chk("bp_rel_deq", 64'(a.req_deq), 64'b01);
    chk("bp_rel_flit", a.out_flit, F1);
    cyc(); a.req_empty = 2'b01; #1;
    chk("single_deq", 64'(a.req_deq), 64'b10);
    chk("single_flit", a.out_flit, F0);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("single_deq", 64'(a.req_deq), 64'b10);
      chk("single_enq", 64'(a.out_enq), 64'b1);
      chk("single_src", 64'(a.out_src), 64'd1);
    end
    cyc(); a.req_empty = 2'b11; #1;
    chk("idle_deq", 64'(a.req_deq), 64'b00);
    chk("single_last_enq", 64'(a.out_enq), 64'b1);
    chk("single_last_src", 64'(a.out_src), 64'd1);
    cyc(); #1;
    chk("drained_enq", 64'(a.out_enq), 64'b0);
    cyc(); a.req_empty = 2'b00; #1;
    chk("pre_rst_deq", 64'(a.req_deq), 64'b01);
    cyc(); rst = 1'b1; #1;
    chk("mid_rst_enq", 64'(a.out_enq), 64'b0);
    chk("mid_rst_deq", 64'(a.req_deq), 64'b00);
    cyc(); rst = 1'b0; #1;
    chk("post_rst_enq", 64'(a.out_enq), 64'b0);
    chk("post_rst_flit", a.out_flit, 64'h0);
    chk("post_rst_ptr0", 64'(a.req_deq), 64'b01);
    cyc(); a.req_empty = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cyc(); b.req_empty = 2'b01; #1;
      chk("bst_pre_deq", 64'(b.req_deq), 64'b10);
    end
    for (int i = 0; i < 7; i++) begin
      cyc(); b.req_empty = 2'b00; #1;
      chk("bst_deq", 64'(b.req_deq), 64'(seq[i]));
      chk("bst_src", 64'(b.out_src), 64'(src_seq[i]));
    end
    cyc(); #1;
    chk("bst_hold2", 64'(b.req_deq), 64'b01);
    cyc(); b.req_empty = 2'b01; #1;
    chk("bst_break", 64'(b.req_deq), 64'b10);
    cyc(); b.req_empty = 2'b11; #1;
    chk("bst_break_src", 64'(b.out_src), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
